mem_access_ctrl: RTL

Memory-stage access initiator that drives the 16-bit data memory's word-level command port (read strobe, write strobe, 16-bit address, write data; registered read data). It accepts one pipeline request at a time: load, store, push or pop, each 16-bit narrow or 32-bit wide. It sequences wide requests as two word accesses and owns the stack pointer. It stalls the pipeline with `req_ready` while a sequence is in flight.

---
 rtl/mem_access_ctrl_pkg.sv | 24 ++
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory-stage access initiator: request ops, FSM states
// and address-space limits.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWr0,
    StWr1,
    StRd0,
    StRd1,
    StRdw
  } state_e;

  localparam logic [15:0] ADDR_MAX = 16'h07FF;
  localparam logic [15:0] SP_INIT  = 16'h07FF;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory-stage access initiator: sequences narrow/wide load, store, push and pop
// requests onto a 16-bit word memory port and owns the stack pointer.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter logic [15:0] AddrMax = ADDR_MAX,
  parameter logic [15:0] SpInit  = SP_INIT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic        i_req_wide,
  input  logic [15:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_addr_err,
  output logic [15:0] o_sp,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata
);

  state_e      r_state;
  logic [15:0] r_sp;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_addr1;
  logic [15:0] r_wdata_lo;
  logic        r_wide;
  logic [15:0] r_hi;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_addr_err;

  op_e         w_op;
  logic [15:0] w_step;
  logic [15:0] w_a0;
  logic [15:0] w_a1;
  logic [15:0] w_sp_next;
  logic        w_is_rd;
  logic        w_err;

  // w_a0 is always the first access (the hi word when wide), w_a1 the second (lo word).
  always_comb begin
    w_op      = op_e'(i_req_op);
    w_step    = i_req_wide ? 16'd2 : 16'd1;
    w_a0      = i_req_addr;
    w_a1      = i_req_addr + 16'd1;
    w_sp_next = r_sp;
    w_is_rd   = (w_op == OP_LOAD) || (w_op == OP_POP);
    case (w_op)
      OP_PUSH: begin
        w_a0      = r_sp;
        w_a1      = r_sp - 16'd1;
        w_sp_next = r_sp - w_step;
      end
      OP_POP: begin
        w_a0      = r_sp + w_step;
        w_a1      = r_sp + 16'd1;
        w_sp_next = r_sp + w_step;
      end
      default: ;
    endcase
    w_err = (w_a0 > AddrMax) || (i_req_wide && (w_a1 > AddrMax));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_sp         <= SpInit;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_addr1      <= '0;
      r_wdata_lo   <= '0;
      r_wide       <= 1'b0;
      r_hi         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_addr_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_addr_err   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_wide     <= i_req_wide;
            r_addr1    <= w_a1;
            r_wdata_lo <= i_req_wdata[15:0];
            if (w_err) begin
              r_addr_err <= 1'b1;
              if (w_is_rd) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= '0;
              end
            end else begin
              r_sp       <= w_sp_next;
              r_mem_addr <= w_a0;
              if (w_is_rd) begin
                r_state    <= StRd0;
                r_mem_read <= 1'b1;
              end else begin
                r_state     <= StWr0;
                r_mem_write <= 1'b1;
                r_mem_wdata <= i_req_wide ? i_req_wdata[31:16] : i_req_wdata[15:0];
              end
            end
          end
        end
        StWr0: begin
          if (r_wide) begin
            r_state     <= StWr1;
            r_mem_addr  <= r_addr1;
            r_mem_wdata <= r_wdata_lo;
          end else begin
            r_state     <= StIdle;
            r_mem_write <= 1'b0;
          end
        end
        StWr1: begin
          r_state     <= StIdle;
          r_mem_write <= 1'b0;
        end
        StRd0: begin
          if (r_wide) begin
            r_state    <= StRd1;
            r_mem_addr <= r_addr1;
          end else begin
            r_state    <= StRdw;
            r_mem_read <= 1'b0;
          end
        end
        StRd1: begin
          // Data from the RD0 access (hi word) is on i_mem_rdata now.
          r_state    <= StRdw;
          r_mem_read <= 1'b0;
          r_hi       <= i_mem_rdata;
        end
        StRdw: begin
          r_state      <= StIdle;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_wide ? {r_hi, i_mem_rdata} : {16'h0000, i_mem_rdata};
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready  = (r_state == StIdle);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_addr_err   = r_addr_err;
  assign o_sp         = r_sp;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule
